// File: rtl/qspi_mem_if.sv
// CPU-side and quad-SPI pin bundle for the qspi_mem byte controller.
// The slave modport is the controller's view; master is the CPU/board side.
`timescale 1ns/1ps

interface qspi_mem_if;
  // CPU control and data bus
  logic [1:0] op;
  logic [1:0] addr_reg_op;
  logic [1:0] addr_sel;
  logic [7:0] bus_data_in;
  logic       op_done_out;
  logic [7:0] bus_data_out;

  // Shared quad-SPI bus
  logic [3:0] spi_data_in;
  logic [3:0] spi_data_out;
  logic [3:0] spi_data_oe;
  logic       spi_clk_out;
  logic       spi_flash_select;
  logic       spi_ram_a_select;
  logic       spi_ram_b_select;

  modport master (
    output op, addr_reg_op, addr_sel, bus_data_in, spi_data_in,
    input  op_done_out, bus_data_out, spi_data_out, spi_data_oe,
           spi_clk_out, spi_flash_select, spi_ram_a_select, spi_ram_b_select
  );

  modport slave (
    input  op, addr_reg_op, addr_sel, bus_data_in, spi_data_in,
    output op_done_out, bus_data_out, spi_data_out, spi_data_oe,
           spi_clk_out, spi_flash_select, spi_ram_a_select, spi_ram_b_select
  );
endinterface

// File: rtl/qspi_mem.sv
// Single-byte QPI READ/WRITE controller for one flash and two PSRAMs on a shared bus.
// Optional MEM_AUTO_INC_EN: post-increment the address register after every transaction.
`timescale 1ns/1ps

module qspi_mem #(
  parameter int DATA_BUS_WIDTH = 8,   // only 8 is supported
  parameter int ADDRESS_WIDTH  = 16
) (
  input  logic      clock,
  input  logic      reset,
  qspi_mem_if.slave bus
);

  localparam logic [1:0] OP_READ    = 2'd1;
  localparam logic [1:0] OP_WRITE   = 2'd2;
  localparam logic [1:0] AR_LOAD_LO = 2'd1;
  localparam logic [1:0] AR_LOAD_HI = 2'd2;
  localparam logic [1:0] AR_INC     = 2'd3;
  localparam logic [1:0] SEL_FLASH  = 2'd0;
  localparam logic [1:0] SEL_NONE   = 2'd3;
  localparam logic [7:0] CMD_READ   = 8'h0B;
  localparam logic [7:0] CMD_WRITE  = 8'h02;

  // Command, 24-bit address and write data are shifted out as one word, MSB nibble first
  localparam int TX_W = 8 + 24 + DATA_BUS_WIDTH;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DUMMY,
    ST_RDATA,
    ST_WDATA,
    ST_DONE
  } state_e;

  state_e                    state_reg,   state_next;
  logic                      phase_reg,   phase_next;
  logic [2:0]                nib_reg,     nib_next;
  logic [TX_W-1:0]           tx_reg,      tx_next;
  logic [3:0]                rd_hi_reg,   rd_hi_next;
  logic                      is_read_reg, is_read_next;
  logic [1:0]                dev_reg,     dev_next;
  logic [ADDRESS_WIDTH-1:0]  addr_reg,    addr_next;
  logic [DATA_BUS_WIDTH-1:0] rdata_reg,   rdata_next;

  logic       active;
  logic       drive;
  logic       op_go;
  logic       no_bus;
  logic [2:0] nib_last;
  logic [2:0] sel_n;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg   <= ST_IDLE;
      phase_reg   <= 1'b0;
      nib_reg     <= '0;
      tx_reg      <= '0;
      rd_hi_reg   <= '0;
      is_read_reg <= 1'b0;
      dev_reg     <= SEL_NONE;
      addr_reg    <= '0;
      rdata_reg   <= '0;
    end else begin
      state_reg   <= state_next;
      phase_reg   <= phase_next;
      nib_reg     <= nib_next;
      tx_reg      <= tx_next;
      rd_hi_reg   <= rd_hi_next;
      is_read_reg <= is_read_next;
      dev_reg     <= dev_next;
      addr_reg    <= addr_next;
      rdata_reg   <= rdata_next;
    end
  end

  always_comb begin
    nib_last = 3'd1;
    case (state_reg)
      ST_ADDR:  nib_last = 3'd5;
      ST_DUMMY: nib_last = 3'd3;
      default:  nib_last = 3'd1;
    endcase
  end

  assign op_go  = (bus.op == OP_READ) || (bus.op == OP_WRITE);
  // Flash is read-only here and target 3 has no device: finish without touching the bus
  assign no_bus = (bus.addr_sel == SEL_NONE) ||
                  ((bus.op == OP_WRITE) && (bus.addr_sel == SEL_FLASH));

  always_comb begin
    state_next   = state_reg;
    phase_next   = phase_reg;
    nib_next     = nib_reg;
    tx_next      = tx_reg;
    rd_hi_next   = rd_hi_reg;
    is_read_next = is_read_reg;
    dev_next     = dev_reg;
    addr_next    = addr_reg;
    rdata_next   = rdata_reg;

    case (state_reg)
      ST_IDLE: begin
        case (bus.addr_reg_op)
          AR_LOAD_LO: addr_next[7:0]               = bus.bus_data_in;
          AR_LOAD_HI: addr_next[ADDRESS_WIDTH-1:8] = bus.bus_data_in;
          AR_INC:     addr_next                    = addr_reg + ADDRESS_WIDTH'(1);
          default:    ;
        endcase
        if (op_go) begin
          is_read_next = (bus.op == OP_READ);
          dev_next     = bus.addr_sel;
          if (no_bus) begin
            state_next = ST_DONE;
            if (bus.op == OP_READ) rdata_next = '1;
          end else begin
            // Latch the pre-update address; a same-cycle addr_reg_op lands afterwards
            state_next = ST_CMD;
            phase_next = 1'b0;
            nib_next   = '0;
            tx_next    = {((bus.op == OP_READ) ? CMD_READ : CMD_WRITE),
                          {(24-ADDRESS_WIDTH){1'b0}}, addr_reg, bus.bus_data_in};
          end
        end
      end

      ST_CMD, ST_ADDR, ST_DUMMY, ST_RDATA, ST_WDATA: begin
        phase_next = ~phase_reg;
        if (phase_reg) begin
          tx_next  = tx_reg << 4;
          nib_next = nib_reg + 3'd1;
          if (state_reg == ST_RDATA) begin
            if (nib_reg == 3'd0) rd_hi_next = bus.spi_data_in;
            else                 rdata_next = {rd_hi_reg, bus.spi_data_in};
          end
          if (nib_reg == nib_last) begin
            nib_next = '0;
            case (state_reg)
              ST_CMD:   state_next = ST_ADDR;
              ST_ADDR:  state_next = is_read_reg ? ST_DUMMY : ST_WDATA;
              ST_DUMMY: state_next = ST_RDATA;
              default:  state_next = ST_DONE;
            endcase
          end
        end
      end

      ST_DONE: begin
        state_next = ST_IDLE;
`ifdef MEM_AUTO_INC_EN
        addr_next  = addr_reg + ADDRESS_WIDTH'(1);
`endif
      end

      default: state_next = ST_IDLE;
    endcase
  end

  assign active = (state_reg == ST_CMD)   || (state_reg == ST_ADDR)  ||
                  (state_reg == ST_DUMMY) || (state_reg == ST_RDATA) ||
                  (state_reg == ST_WDATA);
  assign drive  = (state_reg == ST_CMD) || (state_reg == ST_ADDR) ||
                  (state_reg == ST_WDATA);

  assign bus.spi_clk_out  = active & phase_reg;
  assign bus.spi_data_oe  = drive ? 4'hF : 4'h0;
  assign bus.spi_data_out = drive ? tx_reg[TX_W-1 -: 4] : 4'h0;
  assign bus.op_done_out  = (state_reg == ST_DONE);
  assign bus.bus_data_out = rdata_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_sel
      assign sel_n[gi] = ~(active && (dev_reg == 2'(gi)));
    end
  endgenerate

  assign bus.spi_flash_select = sel_n[0];
  assign bus.spi_ram_a_select = sel_n[1];
  assign bus.spi_ram_b_select = sel_n[2];

endmodule

// File: tb/tb_qspi_mem.sv
// Self-checking bench for qspi_mem: QPI flash/PSRAM device model, vector table and scoreboard.
`timescale 1ns/1ps

module tb_qspi_mem;

  logic clock = 1'b0;
  logic reset;

  qspi_mem_if bus();

  qspi_mem dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // ---------------- device model (flash image + two PSRAMs) ----------------
  logic [7:0] ram_a [int];
  logic [7:0] ram_b [int];

  function automatic logic [7:0] mem_read(input logic [1:0] d, input logic [15:0] a);
    if (d == 2'd0) return a[7:0] ^ 8'hA0;
    if (d == 2'd1) return ram_a.exists(int'(a)) ? ram_a[int'(a)] : ~a[7:0];
    return ram_b.exists(int'(a)) ? ram_b[int'(a)] : ~a[7:0];
  endfunction

  int          mdl_cnt   = 0;
  int          mdl_stray = 0;
  logic [63:0] mdl_sh    = '0;
  logic [31:0] mdl_hdr   = '0;
  logic [7:0]  mdl_wd    = '0;
  logic [1:0]  mdl_dev   = 2'd0;
  logic        prev_clk  = 1'b0;
  logic        prev_any  = 1'b0;

  always @(negedge clock) begin
    logic       any_sel;
    logic [7:0] rb;
    any_sel = !(bus.spi_flash_select && bus.spi_ram_a_select && bus.spi_ram_b_select);
    if (reset) bus.spi_data_in = 4'h0;
    if (any_sel && !prev_any) begin
      mdl_cnt = 0;
      mdl_dev = !bus.spi_flash_select ? 2'd0 : (!bus.spi_ram_a_select ? 2'd1 : 2'd2);
    end
    if (bus.spi_clk_out && !prev_clk) begin
      if (!any_sel) mdl_stray++;
      mdl_sh = {mdl_sh[59:0], bus.spi_data_out};
      mdl_cnt++;
      if (mdl_cnt == 8) mdl_hdr = mdl_sh[31:0];
      if (mdl_cnt == 10 && mdl_hdr[31:24] == 8'h02) begin
        mdl_wd = mdl_sh[7:0];
        if (mdl_dev == 2'd1) ram_a[int'(mdl_hdr[15:0])] = mdl_wd;
        if (mdl_dev == 2'd2) ram_b[int'(mdl_hdr[15:0])] = mdl_wd;
      end
    end
    // Read data goes out after the falling clock edge of the previous nibble
    if (!bus.spi_clk_out && prev_clk && mdl_hdr[31:24] == 8'h0B &&
        (mdl_cnt == 12 || mdl_cnt == 13)) begin
      rb = mem_read(mdl_dev, mdl_hdr[15:0]);
      bus.spi_data_in = (mdl_cnt == 12) ? rb[7:4] : rb[3:0];
    end
    prev_clk = bus.spi_clk_out;
    prev_any = any_sel;
  end

  // ---------------- scoreboard and drivers ----------------
  typedef struct {
    string       name;
    logic [7:0]  data;
    bit          chk_data;
    int          lat;
    int          sel_cyc;
    logic [1:0]  sel;
    bit          bus_ops;
    bit          is_write;
    logic [31:0] hdr;
    logic [7:0]  wdata;
  } exp_t;

  exp_t sb[$];

  task automatic load_addr(input logic [15:0] a);
    bus.addr_reg_op = 2'd2;
    bus.bus_data_in = a[15:8];
    @(negedge clock);
    bus.addr_reg_op = 2'd1;
    bus.bus_data_in = a[7:0];
    @(negedge clock);
    bus.addr_reg_op = 2'd0;
  endtask

  task automatic run_op(input string nm, input logic [1:0] op, input logic [1:0] sel,
                        input logic [15:0] exp_addr, input logic [7:0] wdata,
                        input logic [7:0] exp_data, input logic [1:0] aro);
    exp_t e;
    bit   rd, special, done;
    int   cyc;
    int   lowc [3];
    rd      = (op == 2'd1);
    special = (sel == 2'd3) || (!rd && sel == 2'd0);
    e.name     = nm;
    e.data     = exp_data;
    e.chk_data = rd;
    e.lat      = special ? 1 : (rd ? 29 : 21);
    e.sel_cyc  = special ? 0 : (rd ? 28 : 20);
    e.sel      = sel;
    e.bus_ops  = !special;
    e.is_write = !rd;
    e.hdr      = {(rd ? 8'h0B : 8'h02), 8'h00, exp_addr};
    e.wdata    = wdata;
    sb.push_back(e);

    bus.op          = op;
    bus.addr_sel    = sel;
    bus.bus_data_in = wdata;
    bus.addr_reg_op = aro;
    cyc  = 0;
    done = 0;
    for (int i = 0; i < 3; i++) lowc[i] = 0;
    while (!done && cyc < 40) begin
      @(negedge clock);
      cyc++;
      bus.addr_reg_op = 2'd0;
      if (!bus.spi_flash_select) lowc[0]++;
      if (!bus.spi_ram_a_select) lowc[1]++;
      if (!bus.spi_ram_b_select) lowc[2]++;
      if (bus.op_done_out) begin
        done   = 1;
        bus.op = 2'd0;
      end
    end
    bus.op = 2'd0;

    e = sb.pop_front();
    chk($sformatf("%s_latency", e.name), done ? cyc : 0, e.lat);
    if (e.chk_data) chk($sformatf("%s_data", e.name), bus.bus_data_out, e.data);
    for (int i = 0; i < 3; i++)
      chk($sformatf("%s_sel%0d_low_cycles", e.name, i), lowc[i],
          (i == int'(e.sel)) ? e.sel_cyc : 0);
    if (e.bus_ops) begin
      chk($sformatf("%s_cmd_addr_nibbles", e.name), mdl_hdr, e.hdr);
      chk($sformatf("%s_nibble_count", e.name), mdl_cnt, e.is_write ? 10 : 14);
      if (e.is_write) chk($sformatf("%s_wdata_nibbles", e.name), mdl_wd, e.wdata);
    end
    @(negedge clock);
    chk($sformatf("%s_done_pulse_width", e.name), bus.op_done_out, 0);
    chk($sformatf("%s_idle_oe", e.name), bus.spi_data_oe, 0);
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk($sformatf("%s_selects", nm),
        {bus.spi_flash_select, bus.spi_ram_a_select, bus.spi_ram_b_select}, 3'b111);
    chk($sformatf("%s_oe", nm), bus.spi_data_oe, 4'h0);
    chk($sformatf("%s_done", nm), bus.op_done_out, 1'b0);
    chk($sformatf("%s_data", nm), bus.bus_data_out, 8'h00);
    chk($sformatf("%s_spi_clk", nm), bus.spi_clk_out, 1'b0);
    chk($sformatf("%s_spi_dout", nm), bus.spi_data_out, 4'h0);
  endtask

  typedef struct {
    string      name;
    logic [1:0] op;
    logic [1:0] sel;
    logic [15:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs [11];

  initial begin
    vecs[0]  = '{"rd_flash_5",      2'd1, 2'd0, 16'h0005, 8'h00, 8'hA5};
    vecs[1]  = '{"wr_ram_a_1234",   2'd2, 2'd1, 16'h1234, 8'h5A, 8'h00};
    vecs[2]  = '{"rd_ram_a_1234",   2'd1, 2'd1, 16'h1234, 8'h00, 8'h5A};
    vecs[3]  = '{"wr_ram_b_0010",   2'd2, 2'd2, 16'h0010, 8'h3C, 8'h00};
    vecs[4]  = '{"rd_ram_a_0010",   2'd1, 2'd1, 16'h0010, 8'h00, 8'hEF};
    vecs[5]  = '{"rd_ram_b_0010",   2'd1, 2'd2, 16'h0010, 8'h00, 8'h3C};
    vecs[6]  = '{"wr_flash_5",      2'd2, 2'd0, 16'h0005, 8'h77, 8'h00};
    vecs[7]  = '{"rd_flash_5_again",2'd1, 2'd0, 16'h0005, 8'h00, 8'hA5};
    vecs[8]  = '{"rd_none",         2'd1, 2'd3, 16'h0000, 8'h00, 8'hFF};
    vecs[9]  = '{"wr_none",         2'd2, 2'd3, 16'h0000, 8'h11, 8'h00};
    vecs[10] = '{"rd_flash_abcd",   2'd1, 2'd0, 16'hABCD, 8'h00, 8'h6D};

    reset           = 1'b1;
    bus.op          = 2'd0;
    bus.addr_reg_op = 2'd0;
    bus.addr_sel    = 2'd3;
    bus.bus_data_in = 8'h00;
    repeat (3) @(negedge clock);
    chk_reset_outputs("por");
    reset = 1'b0;
    @(negedge clock);

    for (int i = 0; i < 11; i++) begin
      load_addr(vecs[i].addr);
      run_op(vecs[i].name, vecs[i].op, vecs[i].sel, vecs[i].addr,
             vecs[i].wdata, vecs[i].exp_data, 2'd0);
    end

    // Abort a READ in its 10th cycle
    load_addr(16'h1234);
    bus.op       = 2'd1;
    bus.addr_sel = 2'd1;
    repeat (10) @(negedge clock);
    chk("midread_busy_sel_a", bus.spi_ram_a_select, 1'b0);
    reset = 1'b1;
    #1;
    chk_reset_outputs("midread_reset");
    bus.op = 2'd0;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk_reset_outputs("after_reset");
    run_op("rd_after_reset_addr0", 2'd1, 2'd0, 16'h0000, 8'h00, 8'hA0, 2'd0);

    // INC wraps 0xFFFF -> 0x0000
    load_addr(16'hFFFF);
    bus.addr_reg_op = 2'd3;
    @(negedge clock);
    bus.addr_reg_op = 2'd0;
    run_op("rd_inc_wrap", 2'd1, 2'd0, 16'h0000, 8'h00, 8'hA0, 2'd0);

    // Same-cycle INC with op start: transaction uses the old address
    load_addr(16'h0020);
    run_op("rd_same_cycle_inc", 2'd1, 2'd0, 16'h0020, 8'h00, 8'h80, 2'd3);
`ifdef MEM_AUTO_INC_EN
    run_op("rd_after_inc", 2'd1, 2'd0, 16'h0022, 8'h00, 8'h82, 2'd0);
`else
    run_op("rd_after_inc", 2'd1, 2'd0, 16'h0021, 8'h00, 8'h81, 2'd0);
`endif

    load_addr(16'h0007);
    run_op("rd_0007", 2'd1, 2'd0, 16'h0007, 8'h00, 8'hA7, 2'd0);
`ifdef MEM_AUTO_INC_EN
    run_op("rd_next", 2'd1, 2'd0, 16'h0008, 8'h00, 8'hA8, 2'd0);
`else
    run_op("rd_next", 2'd1, 2'd0, 16'h0007, 8'h00, 8'hA7, 2'd0);
`endif

    chk("stray_spi_clocks", mdl_stray, 0);
    chk("scoreboard_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
